// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: consumes the EX/MEM register, runs a req/ack
// handshake to a multi-cycle data memory, stalls the upstream stages while
// an access is outstanding, resolves the branch and feeds the MEM/WB inputs.
// All state advances on the falling edge of the pipeline clock, so the
// values seen by this block are stable around every falling edge.
module mem_stage_ctrl #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        MemtoReg_in,
    input  logic        RegWrite_in,
    input  logic        MemWrite_in,
    input  logic        MemRead_in,
    input  logic        Branch_in,
    input  logic [31:0] branch_address_in,
    input  logic        ALU_zero_in,
    input  logic [31:0] ALU_result_in,
    input  logic [31:0] Write_data_in,
    input  logic [4:0]  Dst_Reg_in,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        stall,
    output logic        PCSrc,
    output logic [31:0] branch_target,
    output logic        mem_err,
    output logic        MemtoReg_out,
    output logic        RegWrite_out,
    output logic [31:0] Read_data_out,
    output logic [31:0] ALU_result_out,
    output logic [4:0]  Dst_Reg_out
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    // Count value held during the last BUSY cycle before an abort.
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;

    // Memory-side interface registers, held stable while BUSY.
    logic            mem_req_q, mem_req_d;
    logic            mem_we_q, mem_we_d;
    logic [31:0]     mem_addr_q, mem_addr_d;
    logic [31:0]     mem_wdata_q, mem_wdata_d;
    logic            mem_err_q, mem_err_d;

    // Copies of the issuing instruction's write-back controls.
    logic            hold_memtoreg_q, hold_memtoreg_d;
    logic            hold_regwrite_q, hold_regwrite_d;
    logic [4:0]      hold_dst_q, hold_dst_d;
    logic [31:0]     hold_alu_q, hold_alu_d;

    // MEM/WB register inputs.
    logic            memtoreg_out_q, memtoreg_out_d;
    logic            regwrite_out_q, regwrite_out_d;
    logic [31:0]     read_data_q, read_data_d;
    logic [31:0]     alu_out_q, alu_out_d;
    logic [4:0]      dst_out_q, dst_out_d;

    logic            access_s;
    logic            misaligned_s;
    logic            last_wait_s;
    logic            stall_s;

    assign access_s     = MemRead_in | MemWrite_in;
    assign misaligned_s = access_s & (ALU_result_in[1:0] != 2'b00);
    assign last_wait_s  = (count_q == CNT_LAST);

    // Next-state, handshake and MEM/WB forwarding decisions.
    always_comb begin
        state_d         = state_q;
        count_d         = count_q;
        mem_req_d       = mem_req_q;
        mem_we_d        = mem_we_q;
        mem_addr_d      = mem_addr_q;
        mem_wdata_d     = mem_wdata_q;
        mem_err_d       = 1'b0;
        hold_memtoreg_d = hold_memtoreg_q;
        hold_regwrite_d = hold_regwrite_q;
        hold_dst_d      = hold_dst_q;
        hold_alu_d      = hold_alu_q;
        // A bubble is the default MEM/WB payload.
        memtoreg_out_d  = 1'b0;
        regwrite_out_d  = 1'b0;
        read_data_d     = 32'h0000_0000;
        alu_out_d       = 32'h0000_0000;
        dst_out_d       = 5'd0;
        stall_s         = 1'b0;

        case (state_q)
            IDLE: begin
                if (misaligned_s) begin
                    mem_err_d = 1'b1;
                end else if (access_s) begin
                    // A write wins when both read and write are flagged.
                    stall_s         = 1'b1;
                    mem_req_d       = 1'b1;
                    mem_we_d        = MemWrite_in;
                    mem_addr_d      = ALU_result_in;
                    mem_wdata_d     = Write_data_in;
                    hold_memtoreg_d = MemtoReg_in;
                    hold_regwrite_d = RegWrite_in;
                    hold_dst_d      = Dst_Reg_in;
                    hold_alu_d      = ALU_result_in;
                    count_d         = CNT_ZERO;
                    state_d         = BUSY;
                end else begin
                    memtoreg_out_d = MemtoReg_in;
                    regwrite_out_d = RegWrite_in;
                    alu_out_d      = ALU_result_in;
                    dst_out_d      = Dst_Reg_in;
                end
            end
            BUSY: begin
                if (mem_ack) begin
                    memtoreg_out_d = hold_memtoreg_q;
                    regwrite_out_d = hold_regwrite_q;
                    alu_out_d      = hold_alu_q;
                    dst_out_d      = hold_dst_q;
                    read_data_d    = mem_we_q ? 32'h0000_0000 : mem_rdata;
                    mem_req_d      = 1'b0;
                    mem_we_d       = 1'b0;
                    mem_addr_d     = 32'h0000_0000;
                    mem_wdata_d    = 32'h0000_0000;
                    count_d        = CNT_ZERO;
                    state_d        = IDLE;
                end else if (last_wait_s) begin
                    // Release the pipeline one cycle early so the abort edge
                    // also advances EX/MEM past the failed access.
                    mem_err_d   = 1'b1;
                    mem_req_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = 32'h0000_0000;
                    mem_wdata_d = 32'h0000_0000;
                    count_d     = CNT_ZERO;
                    state_d     = IDLE;
                end else begin
                    stall_s = 1'b1;
                    count_d = count_q + CNT_ONE;
                end
            end
            default: begin
                mem_req_d   = 1'b0;
                mem_we_d    = 1'b0;
                mem_addr_d  = 32'h0000_0000;
                mem_wdata_d = 32'h0000_0000;
                count_d     = CNT_ZERO;
                state_d     = IDLE;
            end
        endcase
    end

    // State and output registers, updated on the falling clock edge.
    always_ff @(negedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= IDLE;
            count_q         <= CNT_ZERO;
            mem_req_q       <= 1'b0;
            mem_we_q        <= 1'b0;
            mem_addr_q      <= 32'h0000_0000;
            mem_wdata_q     <= 32'h0000_0000;
            mem_err_q       <= 1'b0;
            hold_memtoreg_q <= 1'b0;
            hold_regwrite_q <= 1'b0;
            hold_dst_q      <= 5'd0;
            hold_alu_q      <= 32'h0000_0000;
            memtoreg_out_q  <= 1'b0;
            regwrite_out_q  <= 1'b0;
            read_data_q     <= 32'h0000_0000;
            alu_out_q       <= 32'h0000_0000;
            dst_out_q       <= 5'd0;
        end else begin
            state_q         <= state_d;
            count_q         <= count_d;
            mem_req_q       <= mem_req_d;
            mem_we_q        <= mem_we_d;
            mem_addr_q      <= mem_addr_d;
            mem_wdata_q     <= mem_wdata_d;
            mem_err_q       <= mem_err_d;
            hold_memtoreg_q <= hold_memtoreg_d;
            hold_regwrite_q <= hold_regwrite_d;
            hold_dst_q      <= hold_dst_d;
            hold_alu_q      <= hold_alu_d;
            memtoreg_out_q  <= memtoreg_out_d;
            regwrite_out_q  <= regwrite_out_d;
            read_data_q     <= read_data_d;
            alu_out_q       <= alu_out_d;
            dst_out_q       <= dst_out_d;
        end
    end

    assign mem_req        = mem_req_q;
    assign mem_we         = mem_we_q;
    assign mem_addr       = mem_addr_q;
    assign mem_wdata      = mem_wdata_q;
    assign mem_err        = mem_err_q;
    // Stall is released as soon as reset is applied, regardless of inputs.
    assign stall          = stall_s & reset_n;
    assign PCSrc          = Branch_in & ALU_zero_in;
    assign branch_target  = branch_address_in;
    assign MemtoReg_out   = memtoreg_out_q;
    assign RegWrite_out   = regwrite_out_q;
    assign Read_data_out  = read_data_q;
    assign ALU_result_out = alu_out_q;
    assign Dst_Reg_out    = dst_out_q;

endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
- MEM-stage controller and consumer of the EX/MEM pipeline register outputs.
- Drives a request/acknowledge handshake to a multi-cycle data memory and stalls upstream stages while an access is outstanding.
- Resolves the branch decision and forwards results into the MEM/WB register inputs.
- All state updates on the falling edge of clock, consistent with the pipeline registers.

Parameters:
TIMEOUT, 16, max falling edges in BUSY waiting for mem_ack before abort (2..255); counter width derived via $clog2(TIMEOUT+1).

Ports:
clock  input  1  pipeline clock; state updates on negedge
reset_n  input  1  asynchronous, active-low reset
MemtoReg_in  input  1  from EX/MEM
RegWrite_in  input  1  from EX/MEM
MemWrite_in  input  1  from EX/MEM
MemRead_in  input  1  from EX/MEM
Branch_in  input  1  from EX/MEM
branch_address_in  input  32  branch target from EX/MEM
ALU_zero_in  input  1  from EX/MEM
ALU_result_in  input  32  memory address / ALU result
Write_data_in  input  32  store data (Read_data2 of EX/MEM)
Dst_Reg_in  input  5  destination register
mem_req  output  1  memory request, held until ack or timeout
mem_we  output  1  1 = store, 0 = load
mem_addr  output  32  latched word address
mem_wdata  output  32  latched store data
mem_ack  input  1  memory acknowledge, sampled on negedge
mem_rdata  input  32  load data, valid when mem_ack=1
stall  output  1  freeze PC, IF/ID, ID/EX, EX/MEM
PCSrc  output  1  Branch_in & ALU_zero_in (combinational)
branch_target  output  32  = branch_address_in (combinational)
mem_err  output  1  one-cycle pulse on misalignment or timeout
MemtoReg_out  output  1  to MEM/WB
RegWrite_out  output  1  to MEM/WB
Read_data_out  output  32  to MEM/WB
ALU_result_out  output  32  to MEM/WB
Dst_Reg_out  output  5  to MEM/WB

Behaviour:
- Reset (asynchronous, any state): state=IDLE, count=0. mem_req, mem_we, mem_err, all *_out, mem_addr and mem_wdata are 0. Any pending request is dropped immediately with no ack wait.
- access = MemRead_in | MemWrite_in.
- misaligned = access & (ALU_result_in[1:0] != 0).
- If MemRead_in and MemWrite_in are both 1, treat the access as a store.
- IDLE, no access: at the negedge, the MEM/WB outputs take the inputs. Read_data_out=0. Latency is 1 edge; no stall.
- IDLE, misaligned: no request, no stall. At the negedge, MEM/WB receives a bubble (all *_out = 0) and mem_err=1 for one cycle.
- IDLE, aligned access:
  - stall=1 combinationally.
  - At the negedge: latch mem_addr=ALU_result_in, mem_wdata=Write_data_in, mem_we=MemWrite_in, and MemtoReg/RegWrite/Dst_Reg/ALU_result into internal holds. Set mem_req=1, count=0, go to BUSY.
  - MEM/WB receives a bubble on this edge.
- BUSY:
  - mem_req, mem_addr, mem_wdata and mem_we are held stable.
  - stall = ~mem_ack, or 0 on the timeout edge.
  - At a negedge with mem_ack=1: Read_data_out = mem_we ? 0 : mem_rdata. Other *_out come from the holds. Set mem_req=0 and go to IDLE.
  - Access latency is 2 edges minimum: issue edge plus ack edge.
  - At a negedge with mem_ack=0: count++. When count reaches TIMEOUT-1 (the TIMEOUT-th edge):
    - set mem_req=0, pulse mem_err, send a bubble to MEM/WB, go to IDLE;
    - stall=0 during the cycle before that edge.
  - While in BUSY with no ack, MEM/WB outputs a bubble every edge.
- mem_ack while in IDLE is ignored.
- On the edge leaving BUSY the EX/MEM register advances. The next instruction is evaluated in IDLE on the following cycle, so no back-to-back issue occurs on the ack edge.
- PCSrc and branch_target are purely combinational from the inputs and are unaffected by state. Branch instructions never set access.
- mem_err is 1 only for the cycle following the erroring edge.

Test Plan:
- Reset: hold reset_n=0 mid-BUSY with mem_req=1 -> mem_req, stall and all *_out drop to 0 immediately; after release, state is IDLE.
- ALU op (RegWrite_in=1, Dst_Reg_in=5'd9, ALU_result_in=32'h0000_002A), no access -> next negedge: RegWrite_out=1, Dst_Reg_out=9, ALU_result_out=32'h2A, Read_data_out=0, stall never 1.
- Load, ALU_result_in=32'h100, mem_ack asserted 3 cycles after mem_req rises, mem_rdata=32'hDEAD_BEEF -> stall=1 for 4 cycles, mem_addr=32'h100 held; at the ack edge Read_data_out=32'hDEADBEEF with MemtoReg_out=1 and RegWrite_out=1; mem_req=0 after the edge.
- Store, ALU_result_in=32'h204, Write_data_in=32'h1234_5678, ack on the first BUSY cycle -> mem_we=1 and mem_wdata=32'h12345678 for one cycle; RegWrite_out=0; stall=1 for exactly 1 cycle.
- Load to ALU_result_in=32'h0000_0102 -> mem_req never rises, mem_err pulses once, MEM/WB bubble, no stall.
- Load with mem_ack held 0 and TIMEOUT=16 -> mem_req high for 16 edges then 0; mem_err pulses once; stall released; a later mem_ack in IDLE is ignored.
- Branch_in=1, ALU_zero_in=1, branch_address_in=32'h40 -> PCSrc=1 and branch_target=32'h40 in the same cycle; with ALU_zero_in=0, PCSrc=0.
